capture_ctrl: RTL and testbench

//  Capture sequencer for the scope front end: owns the arm/trigger/capture life cycle around trigger_logic.

---
 rtl/capture_pkg.sv | 21 ++
 rtl/capture_decim.sv | 42 ++++
 rtl/capture_ctrl.sv | 136 +++++++++++++
 tb/tb_capture_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/capture_pkg.sv
// Shared types and helpers for the capture sequencer.
package capture_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PRE  = 3'd1,
        WAIT = 3'd2,
        POST = 3'd3,
        DONE = 3'd4
    } cap_state_t;

    function automatic int depth_of(input int addr_w);
        return 1 << addr_w;
    endfunction

    // Post-trigger count can never exceed the ring size minus one.
    function automatic int clamp_pos(input int pos, input int depth);
        return (pos > depth - 1) ? depth - 1 : pos;
    endfunction

endpackage

// File: rtl/capture_decim.sv
// Sample-rate decimator: one strobe every 2**exponent enabled clocks.
// The exponent is latched and the counter cleared on the synchronous clear.
module capture_decim #(
    parameter int DEC_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [DEC_W-1:0] exp_in,
    output logic             strobe
);

    localparam int CNT_W = (1 << DEC_W) - 1;

    logic [DEC_W-1:0] exp_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_max;

    // Terminal count is 2**exp_q - 1, i.e. exp_q low bits set.
    always_comb begin
        cnt_max = '0;
        for (int i = 0; i < CNT_W; i++) begin
            cnt_max[i] = (i < int'(exp_q));
        end
    end

    assign strobe = en && (cnt_q == cnt_max);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            exp_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
            exp_q <= exp_in;
        end else if (en) begin
            cnt_q <= strobe ? '0 : cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/capture_ctrl.sv
// Arm/trigger/capture sequencer writing a circular sample RAM around trigger_logic.
// Optional auto-trigger timeout: define CAPTURE_AUTO_TRIG_EN.
module capture_ctrl
    import capture_pkg::*;
#(
    parameter int ADDR_W = 9,
    parameter int DEC_W  = 4,
    parameter int TMO_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] trig_pos,
    input  logic [DEC_W-1:0]  decimator,
    input  logic              triggered,
    input  logic              capture_done_clr,
    output logic              armed,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [ADDR_W-1:0] trig_addr,
    output logic              set_capture_done,
    output logic              capture_done,
    output logic              busy,
    output logic              auto_trig
);

    // Host interface: start and capture_done_clr are single-clock pulses acted on only
    // in IDLE and DONE respectively; triggered is a level honoured only in WAIT.
    localparam int DEPTH = depth_of(ADDR_W);
    localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W + 1)'(DEPTH);

    cap_state_t        state_q, state_n;
    logic [ADDR_W-1:0] waddr_q, waddr_n, trig_addr_q, trig_pos_q, post_cnt_q;
    logic [ADDR_W:0]   pre_cnt_q, pre_target;
    logic              set_done_q, done_q;
    logic              start_acc, running, strobe, we_c, trig_hit, tmo_hit, post_full, post_last;

    assign start_acc  = start && (state_q == IDLE);
    assign running    = (state_q == PRE) || (state_q == WAIT) || (state_q == POST);
    assign pre_target = DEPTH_V - {1'b0, trig_pos_q};
    assign post_full  = (post_cnt_q == trig_pos_q);
    assign post_last  = ((post_cnt_q + ADDR_W'(1)) == trig_pos_q);
    assign we_c       = strobe && running && !((state_q == POST) && post_full);
    assign waddr_n    = waddr_q + ADDR_W'(we_c);
    assign trig_hit   = triggered || tmo_hit;

    capture_decim #(.DEC_W(DEC_W)) u_decim (
        .clk    (clk),
        .rst    (rst),
        .clr    (start_acc),
        .en     (running),
        .exp_in (decimator),
        .strobe (strobe)
    );

`ifdef CAPTURE_AUTO_TRIG_EN
    logic [TMO_W-1:0] tmo_q;
    logic             auto_q;

    assign tmo_hit   = (state_q == WAIT) && (&tmo_q) && !triggered;
    assign auto_trig = auto_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_q  <= '0;
            auto_q <= 1'b0;
        end else if (start_acc) begin
            tmo_q  <= '0;
            auto_q <= 1'b0;
        end else begin
            if ((state_q == WAIT) && strobe && !(&tmo_q)) tmo_q <= tmo_q + TMO_W'(1);
            if (tmo_hit) auto_q <= 1'b1;
        end
    end
`else
    // No timeout counter in this build; a zero-width timer can never expire.
    assign tmo_hit   = (TMO_W < 0);
    assign auto_trig = 1'b0;
`endif

    always_comb begin
        state_n = state_q;
        case (state_q)
            IDLE: if (start) state_n = PRE;
            PRE:  if (we_c && ((pre_cnt_q + (ADDR_W + 1)'(1)) == pre_target)) state_n = WAIT;
            WAIT: if (trig_hit) state_n = POST;
            POST: if (post_full || (we_c && post_last)) state_n = DONE;
            DONE: if (capture_done_clr) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            waddr_q     <= '0;
            trig_addr_q <= '0;
            trig_pos_q  <= '0;
            pre_cnt_q   <= '0;
            post_cnt_q  <= '0;
            set_done_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q    <= state_n;
            waddr_q    <= waddr_n;
            set_done_q <= (state_n == DONE) && (state_q != DONE);

            if (start_acc) begin
                trig_pos_q <= ADDR_W'(clamp_pos(int'(trig_pos), DEPTH));
                pre_cnt_q  <= '0;
            end else if ((state_q == PRE) && we_c) begin
                pre_cnt_q <= pre_cnt_q + (ADDR_W + 1)'(1);
            end

            // trig_addr takes the post-write address when a strobe coincides with the trigger.
            if ((state_q == WAIT) && trig_hit) begin
                trig_addr_q <= waddr_n;
                post_cnt_q  <= '0;
            end else if ((state_q == POST) && we_c) begin
                post_cnt_q <= post_cnt_q + ADDR_W'(1);
            end

            if ((state_n == DONE) && (state_q != DONE)) done_q <= 1'b1;
            else if ((state_q == DONE) && capture_done_clr) done_q <= 1'b0;
        end
    end

    assign armed            = (state_q == WAIT) || (state_q == POST);
    assign we               = we_c;
    assign waddr            = waddr_q;
    assign trig_addr        = trig_addr_q;
    assign set_capture_done = set_done_q;
    assign capture_done     = done_q;
    assign busy             = (state_q != IDLE);

endmodule

// File: tb/tb_capture_ctrl.sv
// Scoreboard bench for capture_ctrl with a cycle-level capture model.
module tb_capture_ctrl;

    localparam int ADDR_W = 4;
    localparam int DEC_W  = 4;
    localparam int TMO_W  = 3;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int WR_W   = 16 + 1 + ADDR_W;
    localparam int DN_W   = 16 + ADDR_W + 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] trig_pos = '0;
    logic [DEC_W-1:0]  decimator = '0;
    logic              triggered = 1'b0;
    logic              capture_done_clr = 1'b0;
    logic              armed, we, set_capture_done, capture_done, busy, auto_trig;
    logic [ADDR_W-1:0] waddr, trig_addr;

    capture_ctrl #(.ADDR_W(ADDR_W), .DEC_W(DEC_W), .TMO_W(TMO_W)) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .trig_pos         (trig_pos),
        .decimator        (decimator),
        .triggered        (triggered),
        .capture_done_clr (capture_done_clr),
        .armed            (armed),
        .we               (we),
        .waddr            (waddr),
        .trig_addr        (trig_addr),
        .set_capture_done (set_capture_done),
        .capture_done     (capture_done),
        .busy             (busy),
        .auto_trig        (auto_trig)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    logic [WR_W-1:0] exp_wq[$];   // {cycle, armed, waddr} per RAM write
    logic [DN_W-1:0] exp_dq[$];   // {cycle, trig_addr, auto_trig} per set_capture_done
    int n_cmp = 0;
    int n_err = 0;
    int base  = 0;
    bit mon_on = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    task automatic push_write(input int c, input logic arm, input int idx, input int cut);
        if (c <= cut) exp_wq.push_back({16'(c), arm, ADDR_W'(base + idx)});
    endtask

    // s: first PRE cycle, r: first cycle triggered is held high, cut: last cycle observed.
    task automatic model_capture(input int s, input int dec, input int tp, input int r,
                                 input int cut, output int done_cyc);
        int p, n, w_last, c_s, k, nthrough, last_post;
        logic auto_f;
        p      = 1 << dec;
        n      = DEPTH - tp;
        w_last = s + p - 1 + (n - 1) * p;
        c_s    = (r > w_last) ? r : w_last + 1;
        auto_f = 1'b0;
`ifdef CAPTURE_AUTO_TRIG_EN
        begin
            int t_auto;
            t_auto = s + p - 1 + (n + (1 << TMO_W) - 2) * p + 1;
            if (t_auto < c_s) begin
                c_s    = t_auto;
                auto_f = 1'b1;
            end
        end
`endif
        k = 0;
        while (s + p - 1 + k * p <= c_s) begin
            push_write(s + p - 1 + k * p, k >= n, k, cut);
            k++;
        end
        nthrough  = k;
        last_post = c_s;
        for (int j = 0; j < tp; j++) begin
            last_post = s + p - 1 + (k + j) * p;
            push_write(last_post, 1'b1, k + j, cut);
        end
        done_cyc = (tp == 0) ? c_s + 2 : last_post + 1;
        if (done_cyc <= cut) exp_dq.push_back({16'(done_cyc), ADDR_W'(base + nthrough), auto_f});
        base = (base + nthrough + tp) % DEPTH;
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [WR_W-1:0] ew;
        logic [DN_W-1:0] ed;
        if (mon_on) begin
            if (we) begin
                if (exp_wq.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL write_unexpected: got waddr %0h at cycle %0d, expected no write", waddr, cyc);
                end else begin
                    ew = exp_wq.pop_front();
                    check("write", {16'(cyc), armed, waddr}, 32'(ew));
                end
            end
            if (set_capture_done) begin
                if (exp_dq.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL done_unexpected: got set_capture_done at cycle %0d, expected none", cyc);
                end else begin
                    ed = exp_dq.pop_front();
                    check("done_pulse", {16'(cyc), trig_addr, auto_trig}, 32'(ed));
                end
            end
        end
    end

    // ---------------- driver ----------------
    task automatic check_reset_outputs(input string tag);
        check({tag, "_armed"}, armed, 0);
        check({tag, "_we"}, we, 0);
        check({tag, "_set_done"}, set_capture_done, 0);
        check({tag, "_done"}, capture_done, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_auto"}, auto_trig, 0);
        check({tag, "_waddr"}, waddr, 0);
        check({tag, "_trig_addr"}, trig_addr, 0);
    endtask

    // mode 0: PRE glitch then late trigger; 1: level raised anywhere; 2: trigger at WAIT entry.
    task automatic run_capture(input int dec, input int tp, input int mode, input bit rst_test);
        int s, p, n, w_last, r, g, cut, done_cyc, end_i;
        @(posedge clk); #1;
        s      = cyc + 1;
        p      = 1 << dec;
        n      = DEPTH - tp;
        w_last = s + p - 1 + (n - 1) * p;
        g      = -1;
        case (mode)
            0: begin
                g = $urandom_range(w_last, s);
                r = w_last + 1 + $urandom_range(20, 0);
            end
            1: r = $urandom_range(w_last + 3, s);
            default: r = w_last + 1;
        endcase
        cut = rst_test ? w_last + 4 : 32'h3fff_ffff;
        model_capture(s, dec, tp, r, cut, done_cyc);
        end_i = rst_test ? cut : done_cyc;

        start     = 1'b1;
        decimator = DEC_W'(dec);
        trig_pos  = ADDR_W'(tp);
        for (int i = s; i <= end_i; i++) begin
            @(posedge clk); #1;
            start = (i == s + 1);
            if (start) begin
                trig_pos  = ADDR_W'($urandom);
                decimator = DEC_W'($urandom);
            end
            capture_done_clr = (i == s + 2);
            triggered        = (i == g) || (i >= r);
            rst              = rst_test && (i == end_i);
        end

        @(posedge clk); #1;
        triggered        = 1'b0;
        capture_done_clr = 1'b0;
        start            = 1'b0;
        if (rst_test) begin
            check_reset_outputs("abort");
            rst  = 1'b0;
            base = 0;
        end else begin
            check("done_sticky", capture_done, 1);
            check("busy_in_done", busy, 1);
            check("armed_in_done", armed, 0);
            check("set_done_width", set_capture_done, 0);
            capture_done_clr = 1'b1;
            @(posedge clk); #1;
            capture_done_clr = 1'b0;
            check("done_cleared", capture_done, 0);
            check("busy_idle", busy, 0);
        end
        check("writes_drained", exp_wq.size(), 0);
        check("dones_drained", exp_dq.size(), 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst    = 1'b0;
        mon_on = 1'b1;

        run_capture(0, 4, 0, 1'b0);    // basic capture with address wrap
        run_capture(2, 6, 0, 1'b0);    // decimation by 4
        run_capture(0, 5, 1, 1'b0);    // trigger level raised during PRE
        run_capture(0, 8, 2, 1'b1);    // reset during POST
        run_capture(0, 0, 2, 1'b0);    // no post-trigger samples
        run_capture(1, 15, 0, 1'b0);   // maximum post-trigger count
        for (int t = 0; t < 8; t++) begin
            run_capture($urandom_range(2, 0), $urandom_range(15, 0), $urandom_range(2, 0), 1'b0);
        end

        repeat (4) @(posedge clk);
        #1;
        check("final_writes_drained", exp_wq.size(), 0);
        check("final_dones_drained", exp_dq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
